dm_port_arbiter: RTL

- Shares one single-port memory bus between the instruction-fetch requester and the load/store unit requester.
- Captures one request at a time, drives it onto the memory bus with a req/gnt handshake, and routes the response back to the owner.
- Uses a response timeout to generate an error response.
- Sits between the fetch stage and execute-unit LSU outputs on one side, and the unified memory on the other. Core stalls are derived from the requester gnt/rvalid outputs.

---
 rtl/dm_port_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// Shares one single-port memory bus between fetch and LSU, one transaction at a time; grant is same-cycle in IDLE,
// response is routed back combinationally; requesters stall on gnt and memory stalls via gnt/rvalid, with a WAIT timeout.
module dm_port_arbiter #(
  parameter int XLEN          = 32,
  parameter int MAX_LS_STREAK = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [XLEN-1:0]   i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [XLEN-1:0]   o_if_rdata,
  output logic              o_if_err,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [XLEN-1:0]   i_ls_addr,
  input  logic [XLEN-1:0]   i_ls_wdata,
  input  logic [XLEN/8-1:0] i_ls_wstrb,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [XLEN-1:0]   o_ls_rdata,
  output logic              o_ls_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_wstrb,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  logic [1:0]        state;
  logic              owner_ls;
  logic              we_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN/8-1:0] wstrb_q;
  logic [3:0]        streak;
  logic [7:0]        tcnt;

  logic ls_win;
  logic if_win;
  logic resp;
  logic timed_out;
  logic [XLEN-1:0] resp_data;

  // Gating with reset keeps grants low while reset is held, even with requests pending.
  always_comb begin
    ls_win    = i_rst_n && (state == IDLE) && i_ls_req &&
                !(i_if_req && (streak == STREAK_MAX));
    if_win    = i_rst_n && (state == IDLE) && i_if_req && !ls_win;
    timed_out = (state == WAIT) && !i_mem_rvalid && (tcnt == TO_LAST);
    resp      = (state == WAIT) && (i_mem_rvalid || (tcnt == TO_LAST));
    resp_data = i_mem_rvalid ? i_mem_rdata : '0;
  end

  always_comb begin
    o_if_gnt    = if_win;
    o_ls_gnt    = ls_win;
    o_if_rvalid = resp && !owner_ls;
    o_ls_rvalid = resp && owner_ls;
    o_if_rdata  = (resp && !owner_ls) ? resp_data : '0;
    o_ls_rdata  = (resp && owner_ls) ? resp_data : '0;
    o_if_err    = timed_out && !owner_ls;
    o_ls_err    = timed_out && owner_ls;
    o_mem_req   = (state == ISSUE);
    o_mem_we    = (state == ISSUE) && we_q;
    o_mem_addr  = (state == ISSUE) ? addr_q : '0;
    o_mem_wdata = (state == ISSUE) ? wdata_q : '0;
    o_mem_wstrb = (state == ISSUE) ? wstrb_q : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      owner_ls <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      streak   <= '0;
      tcnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ls_win || if_win) begin
            owner_ls <= ls_win;
            addr_q   <= ls_win ? i_ls_addr : i_if_addr;
            we_q     <= ls_win && i_ls_we;
            wdata_q  <= ls_win ? i_ls_wdata : '0;
            wstrb_q  <= ls_win ? i_ls_wstrb : '0;
            state    <= ISSUE;
          end
          // Only contested LSU wins count toward forcing a fetch grant.
          if (if_win) begin
            streak <= '0;
          end else if (ls_win && i_if_req) begin
            streak <= streak + 4'd1;
          end
        end
        ISSUE: begin
          if (i_mem_gnt) begin
            state <= WAIT;
            tcnt  <= '0;
          end
        end
        WAIT: begin
          if (resp) begin
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
